button_input_port: RTL

//  Input-side peripheral for the Nandgame CPU SoC: the inbound counterpart of the seven-segment/LED output path.

---
 rtl/button_input_port.sv | 90 +++++++++
 1 files changed

// File: rtl/button_input_port.sv
// Synchronised, debounced button/switch input port for the Nandgame SoC.
// Keeps a stable level word plus sticky rising-edge event flags that clear when read.
module button_input_port #(
    parameter int N_IN            = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic            clk,
    input  logic            p_sync_reset,
    input  logic [N_IN-1:0] btn_i,
    input  logic            rd_en_i,
    input  logic            rd_sel_i,
    output logic [15:0]     data_o,
    output logic            rd_valid_o,
    output logic            event_pending_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q;
    logic [N_IN-1:0]                  synced;
    logic [N_IN-1:0]                  stable_q, stable_d;
    logic [N_IN-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_IN-1:0]                  event_q, event_d;
    logic [N_IN-1:0]                  rise;
    logic                             rd_clr;
    logic [15:0]                      level_word, event_word;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (p_sync_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
        end
    end

    // A pin must disagree with its stable value on CNT_MAX+1 consecutive edges before it is accepted.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < N_IN; i++) begin
            if (synced[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = synced[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // A read of the event word clears only what it captured; a rise in the same cycle survives.
    always_comb begin
        rise    = stable_d & ~stable_q;
        rd_clr  = rd_en_i && rd_sel_i;
        event_d = rd_clr ? rise : (event_q | rise);
    end

    always_comb begin
        level_word             = '0;
        event_word             = '0;
        level_word[N_IN-1:0]   = stable_q;
        event_word[N_IN-1:0]   = event_q;
    end

    always_ff @(posedge clk) begin
        if (p_sync_reset) begin
            stable_q   <= '0;
            cnt_q      <= '0;
            event_q    <= '0;
            data_o     <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            event_q    <= event_d;
            rd_valid_o <= rd_en_i;
            if (rd_en_i) begin
                data_o <= rd_sel_i ? event_word : level_word;
            end
        end
    end

    assign event_pending_o = |event_q;

endmodule
